// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants
// used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_TICK   = 7;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit; both flops
// load RST_VAL on synchronous reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, optional parity, configurable
// stop period; presents each frame with a one-cycle rx_done_tick.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            parity_err,
    output logic            frame_err
);

    // Tick counter must also reach SB_TICK-1 during long stop periods.
    localparam int S_RANGE = (SB_TICK > int'(OVERSAMPLE)) ? SB_TICK : int'(OVERSAMPLE);
    localparam int SW      = $clog2(S_RANGE);
    localparam int NW      = $clog2(DBIT);

    localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic          PAR_EN  = (PARITY_EN != 0);
    localparam logic          PAR_ODD = (PARITY_ODD != 0);

    logic            w_rxs;
    uart_state_t     r_state;
    logic [SW-1:0]   r_s;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_b;
    logic            r_p;
    logic [DBIT-1:0] r_dout;
    logic            r_done;
    logic            r_parity_err;
    logic            r_frame_err;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .i_d  (rx),
        .o_q  (w_rxs)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_s          <= '0;
            r_n          <= '0;
            r_b          <= '0;
            r_p          <= 1'b0;
            r_dout       <= '0;
            r_done       <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state <= START;
                        r_s     <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (r_s == S_MID) begin
                            r_s <= '0;
                            r_n <= '0;
                            // A high line at the start midpoint is a glitch, not a frame.
                            r_state <= w_rxs ? IDLE : DATA;
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (r_s == S_BIT) begin
                            r_s <= '0;
                            r_b <= {w_rxs, r_b[DBIT-1:1]};
                            if (r_n == N_LAST) begin
                                r_state <= PAR_EN ? PARITY : STOP;
                            end else begin
                                r_n <= r_n + NW'(1);
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (s_tick) begin
                        if (r_s == S_BIT) begin
                            r_s     <= '0;
                            r_p     <= w_rxs;
                            r_state <= STOP;
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (r_s == S_STOP) begin
                            r_s          <= '0;
                            r_dout       <= r_b;
                            r_frame_err  <= ~w_rxs;
                            r_parity_err <= PAR_EN & (^r_b ^ r_p ^ PAR_ODD);
                            r_done       <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign parity_err   = r_parity_err;
    assign frame_err    = r_frame_err;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver; the receive-side counterpart of the existing uart_tx, and shares its s_tick oversampling-tick interface.
- Samples the asynchronous rx line at 16 ticks per bit and deserialises an LSB-first frame: start bit, DBIT data bits, optional parity bit, stop period.
- Presents the byte on dout with a one-cycle rx_done_tick plus error flags, for the UART FIFO/interface logic.

Parameters:
- DBIT, 8, number of data bits per frame (5..9).
- SB_TICK, 16, s_ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock; everything is clocked on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idle high.
- s_tick  input  1  oversampling enable, 16 per bit period, one clk wide.
- dout  output  DBIT  received data word.
- rx_done_tick  output  1  one-cycle pulse: frame complete, dout and flags valid.
- parity_err  output  1  parity mismatch on the last frame.
- frame_err  output  1  stop bit sampled low on the last frame.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- rx passes through a 2-FF synchronizer. Both flops reset to 1. The FSM uses only the synchronized value, rxs.
- Registers:
  - state
  - s: 4-bit tick counter, or wide enough for SB_TICK-1 in STOP
  - n: bit counter
  - b: DBIT shift register
  - p: parity sample
- Reset values: state=IDLE, s=0, n=0, b=0, dout=0, rx_done_tick=0, parity_err=0, frame_err=0.
- States:
  - IDLE: when rxs=0 (independent of s_tick), go to START with s=0.
  - START: on each s_tick, s++. When s_tick and s==7:
    - rxs=0: go to DATA, s=0, n=0.
    - rxs=1: false start; go to IDLE with no pulse and no flag change.
  - DATA: on each s_tick, s++ (wraps). When s_tick and s==15:
    - b <= {rxs, b[DBIT-1:1]} (LSB first).
    - If n==DBIT-1: go to PARITY when PARITY_EN, else STOP. Otherwise n++.
  - PARITY: when s_tick and s==15, p<=rxs, go to STOP, s=0.
  - STOP: when s_tick and s==SB_TICK-1, in the same edge:
    - dout <= b.
    - frame_err <= ~rxs.
    - parity_err <= PARITY_EN & (^b ^ p ^ PARITY_ODD).
    - rx_done_tick <= 1.
    - Go to IDLE.
- rx_done_tick is high for exactly one clock; it is cleared on every other edge.
- dout and both flags hold until the next completed frame.
- A frame with frame_err=1 still updates dout and pulses rx_done_tick.
- No re-arm guard: if rxs is already 0 at the return to IDLE (break condition), a new START begins on the next edge.
- Counters advance only on s_tick. Without s_tick the FSM holds state indefinitely.
- Timing with s_tick=1 every cycle, PARITY_EN=0, SB_TICK=16. Edge 0 is the first edge at which the rx low level is registered.
  - Edge 2: enter START.
  - Edge 10: enter DATA.
  - Data bit k is sampled at edge 26+16k.
  - rx_done_tick is high after edge 154.
  - PARITY_EN=1 adds 16 edges.
- Reset asserted mid-frame: abort immediately, return to reset values, no pulse. Reset wins over any simultaneous transition.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP), also used by uart_tx.
  - OVERSAMPLE=16.
  - MID_TICK=7.
- One sub-module, sync_2ff: the generic 2-flop synchronizer with a reset-value parameter, set to 1 here.

Test Plan:
- 0xBE framed at 16 clocks/bit, s_tick=1 → dout=0xBE, rx_done_tick high only after edge 154, frame_err=0, parity_err=0.
- Same frame with the stop bit driven 0 → dout=0xBE, frame_err=1, one rx_done_tick; the next clean 0x55 frame → frame_err=0, dout=0x55.
- 4-clock low glitch on idle rx → FSM returns to IDLE at the start midpoint, no rx_done_tick, dout unchanged.
- PARITY_EN=1, even parity, 0x0F sent with parity bit 1 → parity_err=1. The same byte with parity bit 0 → parity_err=0.
- Reset pulsed at edge 60 of a 0xA5 frame → no pulse, all outputs 0; a following 0x3C frame is received correctly.
- s_tick every 4th clock (64 clocks/bit), back-to-back 0x00, 0xFF → two rx_done_ticks with dout 0x00 then 0xFF, no errors.
